pu_read_arbiter: RTL and testbench

- Shares the single read port of the img2col feature-map line buffer among NUM_PU processing units (PUs).
- Each PU requests a fixed-length burst of consecutive reads, one kernel row of BURST_LEN pixels, starting at its own base address.
- Arbitration is round-robin. Read-data validity and ownership tags are returned one cycle after each read.
- Sits between the mapping controller's PU array and the line-buffer SRAM.

---
 rtl/img2col_pkg.sv | 13 +
 rtl/rr_picker.sv | 24 ++
 rtl/pu_read_arbiter.sv | 89 ++++++++
 tb/tb_pu_read_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/img2col_pkg.sv
// img2col_pkg: shared types, default sizes and index helpers for the img2col PU read path
package img2col_pkg;
  typedef enum logic [0:0] {IDLE, BURST} state_t;
  localparam int NUM_PU_DEF = 28;
  localparam int BURST_LEN_DEF = 5;
  localparam int ADDR_W_DEF = 10;
  function automatic int pu_wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction
  function automatic int pu_wrap_add(input int a, input int b, input int n);
    return (a + b >= n) ? a + b - n : a + b;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority encoder, first requester at or above rr_ptr
module rr_picker
  import img2col_pkg::*;
#(
  parameter int NUM_PU = NUM_PU_DEF,
  parameter int ID_W = 5
) (
  input  logic [NUM_PU-1:0] req,
  input  logic [ID_W-1:0]   rr_ptr,
  output logic              found,
  output logic [ID_W-1:0]   index
);
  // scan from the farthest offset down so the nearest requester wins
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_PU - 1; i >= 0; i--) begin
      if (req[pu_wrap_add(int'(rr_ptr), i, NUM_PU)]) begin
        found = 1'b1;
        index = ID_W'(pu_wrap_add(int'(rr_ptr), i, NUM_PU));
      end
    end
  end
endmodule

// File: rtl/pu_read_arbiter.sv
// pu_read_arbiter: round-robin burst arbiter sharing the line-buffer read port among PUs
module pu_read_arbiter
  import img2col_pkg::*;
#(
  parameter int NUM_PU = NUM_PU_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ID_W = 5
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           enable,
  input  logic [NUM_PU-1:0]              req,
  input  logic [NUM_PU-1:0][ADDR_W-1:0]  req_addr,
  input  logic                           mem_stall,
  output logic [NUM_PU-1:0]              grant,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           rd_valid,
  output logic [ID_W-1:0]                rd_pu_id,
  output logic [3:0]                     rd_beat,
  output logic                           burst_done,
  output logic                           busy
);
  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_owner;
  logic [3:0]        r_beat_cnt;
  logic [ADDR_W-1:0] r_base;
  logic              r_rd_valid;
  logic [ID_W-1:0]   r_rd_pu_id;
  logic [3:0]        r_rd_beat;
  logic              w_found;
  logic [ID_W-1:0]   w_pick;
  logic              w_busy;
  logic              w_rd_en;
  logic              w_last;

  rr_picker #(.NUM_PU(NUM_PU), .ID_W(ID_W)) u_picker (
    .req   (req),
    .rr_ptr(r_rr_ptr),
    .found (w_found),
    .index (w_pick)
  );

  // outputs derive only from registered state, so req never reaches grant combinationally
  assign w_busy = r_state == BURST;
  assign w_rd_en = w_busy && !mem_stall;
  assign w_last = r_beat_cnt == 4'(BURST_LEN - 1);
  assign grant = w_busy ? (NUM_PU'(1) << r_owner) : '0;
  assign mem_rd_en = w_rd_en;
  assign mem_addr = w_busy ? r_base + ADDR_W'(r_beat_cnt) : '0;
  assign burst_done = w_rd_en && w_last;
  assign busy = w_busy;
  assign rd_valid = r_rd_valid;
  assign rd_pu_id = r_rd_pu_id;
  assign rd_beat = r_rd_beat;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_rr_ptr <= '0;
      r_owner <= '0;
      r_beat_cnt <= '0;
      r_base <= '0;
      r_rd_valid <= 1'b0;
      r_rd_pu_id <= '0;
      r_rd_beat <= '0;
    end else begin
      r_rd_valid <= w_rd_en;
      r_rd_pu_id <= r_owner;
      r_rd_beat <= r_beat_cnt;
      if (r_state == IDLE) begin
        if (enable && w_found) begin
          r_state <= BURST;
          r_owner <= w_pick;
          r_base <= req_addr[w_pick];
          r_beat_cnt <= '0;
        end
      end else if (w_rd_en) begin
        r_beat_cnt <= r_beat_cnt + 4'd1;
        if (w_last) begin
          r_state <= IDLE;
          r_rr_ptr <= ID_W'(pu_wrap_inc(int'(r_owner), NUM_PU));
        end
      end
    end
  end
endmodule

// File: tb/tb_pu_read_arbiter.sv
// tb_pu_read_arbiter: directed stimulus with queued expectations checked by an independent monitor
module tb_pu_read_arbiter;
  localparam int N = 28;
  localparam int AW = 10;
  localparam int BL = 5;
  localparam int IW = 5;

  typedef struct {
    int addr;
    int pu;
    int beat;
    int done;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  nrst = 1'b0;
  logic                  enable = 1'b1;
  logic [N-1:0]          req = '0;
  logic [N-1:0][AW-1:0]  req_addr = '0;
  logic                  mem_stall = 1'b0;
  logic [N-1:0]          grant;
  logic                  mem_rd_en;
  logic [AW-1:0]         mem_addr;
  logic                  rd_valid;
  logic [IW-1:0]         rd_pu_id;
  logic [3:0]            rd_beat;
  logic                  burst_done;
  logic                  busy;

  exp_t mq[$];
  exp_t rq[$];
  int   done_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  pu_read_arbiter #(.NUM_PU(N), .ADDR_W(AW), .BURST_LEN(BL), .ID_W(IW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .enable    (enable),
    .req       (req),
    .req_addr  (req_addr),
    .mem_stall (mem_stall),
    .grant     (grant),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .rd_valid  (rd_valid),
    .rd_pu_id  (rd_pu_id),
    .rd_beat   (rd_beat),
    .burst_done(burst_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_burst(input int pu, input int base);
    for (int i = 0; i < BL; i++) begin
      mq.push_back('{(base + i) % (1 << AW), pu, i, int'(i == BL - 1)});
      rq.push_back('{0, pu, i, 0});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n);
    int seen = 0;
    int t = 0;
    while (seen < n && t < 200) begin
      @(negedge clk);
      t++;
      if (burst_done) seen++;
    end
    chk("wait_done", seen, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_rd_valid"}, int'(rd_valid), 0);
    chk({tag, "_rd_pu_id"}, int'(rd_pu_id), 0);
    chk({tag, "_rd_beat"}, int'(rd_beat), 0);
    chk({tag, "_done"}, int'(burst_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // monitor: pops expectations whenever the DUT issues a read or returns data
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (busy) begin
      busy_cnt++;
      chk("rd_en_vs_stall", int'(mem_rd_en), int'(!mem_stall));
      chk("grant_onehot", int'($onehot(grant)), 1);
    end
    if (burst_done) done_cyc.push_back(cyc);
    if (mem_rd_en) begin
      if (mq.size() == 0) chk("unexpected_read", 1, 0);
      else begin
        e = mq.pop_front();
        chk("mem_addr", int'(mem_addr), e.addr);
        chk("grant", int'(grant), 1 << e.pu);
        chk("burst_done", int'(burst_done), e.done);
      end
    end else if (burst_done) chk("done_without_read", 1, 0);
    if (rd_valid) begin
      if (rq.size() == 0) chk("unexpected_rd_valid", 1, 0);
      else begin
        e = rq.pop_front();
        chk("rd_pu_id", int'(rd_pu_id), e.pu);
        chk("rd_beat", int'(rd_beat), e.beat);
      end
    end
  end

  initial begin
    int b0;
    int n0;
    #2;
    chk_all_zero("reset");
    #10 nrst = 1'b1;
    // contention from rr_ptr=0: order 0, 5, 27, 0
    tick();
    req_addr[0] = AW'(200);
    req_addr[5] = AW'(300);
    req_addr[27] = AW'(400);
    req[0] = 1'b1;
    req[5] = 1'b1;
    req[27] = 1'b1;
    push_burst(0, 200);
    push_burst(5, 300);
    push_burst(27, 400);
    push_burst(0, 200);
    n0 = done_cyc.size();
    wait_done(4);
    tick();
    req = '0;
    chk("done_count", done_cyc.size() - n0, 4);
    if (done_cyc.size() - n0 == 4)
      for (int i = 1; i < 4; i++) chk("burst_spacing", done_cyc[n0 + i] - done_cyc[n0 + i - 1], BL + 1);
    // single PU 3 at base 100, rr_ptr=1
    tick();
    req_addr[3] = AW'(100);
    req[3] = 1'b1;
    push_burst(3, 100);
    b0 = busy_cnt;
    @(negedge clk);
    chk("latency_idle_grant", int'(grant), 0);
    @(negedge clk);
    chk("latency_first_grant", int'(grant), 8);
    chk("latency_first_addr", int'(mem_addr), 100);
    wait_done(1);
    tick();
    req = '0;
    chk("single_busy_cycles", busy_cnt - b0, BL);
    @(negedge clk);
    chk("single_idle_after", int'(busy), 0);
    // stall plus address wrap: PU 7 at 1022, rr_ptr=4
    tick();
    req_addr[7] = AW'(1022);
    req[7] = 1'b1;
    push_burst(7, 1022);
    b0 = busy_cnt;
    tick();
    for (int c = 1; c < 9; c++) begin
      tick();
      mem_stall = (c == 2 || c == 3 || c == 6 || c == 7);
    end
    wait_done(1);
    tick();
    req = '0;
    mem_stall = 1'b0;
    chk("stall_busy_cycles", busy_cnt - b0, 9);
    // enable dropped mid-burst: PU 10, rr_ptr=8
    tick();
    req_addr[10] = AW'(50);
    req[10] = 1'b1;
    push_burst(10, 50);
    tick();
    tick();
    tick();
    enable = 1'b0;
    req = '1;
    wait_done(1);
    tick();
    b0 = busy_cnt;
    repeat (10) tick();
    chk("disabled_busy_cycles", busy_cnt - b0, 0);
    chk("disabled_grant", int'(grant), 0);
    req = '0;
    enable = 1'b1;
    // async reset during beat 2 of PU 12 burst, rr_ptr=11
    tick();
    req_addr[12] = AW'(500);
    req[12] = 1'b1;
    mq.push_back('{500, 12, 0, 0});
    mq.push_back('{501, 12, 1, 0});
    rq.push_back('{0, 12, 0, 0});
    tick();
    tick();
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk_all_zero("midreset");
    req_addr[2] = AW'(600);
    req[2] = 1'b1;
    push_burst(2, 600);
    push_burst(12, 500);
    @(negedge clk);
    #1 nrst = 1'b1;
    wait_done(1);
    tick();
    req[2] = 1'b0;
    wait_done(1);
    tick();
    req = '0;
    repeat (3) tick();
    chk("mem_queue_empty", mq.size(), 0);
    chk("ret_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
